// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 memory access unit: opcode encoding, FSM states,
// default ready-wait limit.
package lc3_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_LDI = 2'b10,
    OP_STI = 2'b11
  } lc3_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC1,
    ST_ACC2,
    ST_DONE
  } lc3_state_t;

  localparam int LC3_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lc3_mem_access_if.sv
// Request/response and memory-port bundle for lc3_mem_access.
// slave = the access unit, master = the requester/memory side.
interface lc3_mem_access_if;
  import lc3_pkg::*;

  logic        i_req;
  lc3_op_t     i_op;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_rdata;
  logic        o_err;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        i_mem_r;

  modport slave (
    input  i_req, i_op, i_addr, i_wdata, i_mem_rdata, i_mem_r,
    output o_busy, o_done, o_rdata, o_err,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req, i_op, i_addr, i_wdata, i_mem_rdata, i_mem_r,
    input  o_busy, o_done, o_rdata, o_err,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/lc3_mem_watchdog.sv
// Per-access wait counter; expired rises once LIMIT wait cycles have elapsed
// since the last clear. Used only when LC3_MEM_TIMEOUT_EN is defined.
module lc3_mem_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (run && !expired)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 LD/ST/LDI/STI memory access sequencer (MAR/MDR + ready handshake).
// Optional ready timeout enabled by defining LC3_MEM_TIMEOUT_EN.
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LC3_TIMEOUT_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  lc3_mem_access_if.slave  bus
);

  lc3_state_t  state;
  lc3_op_t     op;
  logic [15:0] mar, mdr, wdata_q;
  logic        mem_en, mem_we, done, err;
  logic        timeout;

`ifdef LC3_MEM_TIMEOUT_EN
  // Counter restarts on entry to each access phase (IDLE->ACC1, ACC1->ACC2).
  logic wd_clr, wd_run;
  assign wd_clr = (state == ST_IDLE) ||
                  ((state == ST_ACC1) && bus.i_mem_r && (op == OP_LDI || op == OP_STI));
  assign wd_run = (state == ST_ACC1) || (state == ST_ACC2);

  lc3_mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (wd_clr),
    .run     (wd_run),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      op      <= OP_LD;
      mar     <= '0;
      mdr     <= '0;
      wdata_q <= '0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (bus.i_req) begin
          op      <= bus.i_op;
          mar     <= bus.i_addr;
          wdata_q <= bus.i_wdata;
          err     <= 1'b0;
          mem_en  <= 1'b1;
          mem_we  <= (bus.i_op == OP_ST);
          state   <= ST_ACC1;
        end
        ST_ACC1: if (bus.i_mem_r) begin
          if (op == OP_LD || op == OP_ST) begin
            if (op == OP_LD) mdr <= bus.i_mem_rdata;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            // Pointer fetched; en stays high into the final access.
            mar    <= bus.i_mem_rdata;
            mem_we <= (op == OP_STI);
            state  <= ST_ACC2;
          end
        end else if (timeout) begin
          mdr    <= '0;
          err    <= 1'b1;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_ACC2: if (bus.i_mem_r) begin
          if (op == OP_LDI) mdr <= bus.i_mem_rdata;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end else if (timeout) begin
          mdr    <= '0;
          err    <= 1'b1;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_done      = done;
  assign bus.o_rdata     = mdr;
  assign bus.o_err       = err;
  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mar;
  assign bus.o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed bench for lc3_mem_access with a behavioural memory that adds
// programmable ready delay and can stall after a number of grants.
module tb_lc3_mem_access;
  import lc3_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  lc3_mem_access_if bus();

  lc3_mem_access #(.TIMEOUT_CYCLES(255)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];
  int          mem_delay = 0;
  int          grants_left = 1000000;
  int          wcnt = 0;
  int          wr_count = 0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  int          done_cnt = 0;

  // Memory model: after mem_delay idle cycles of o_mem_en, assert ready for
  // one cycle; writes are committed on the granted cycle.
  always @(negedge i_clk) begin
    if (bus.o_mem_en && grants_left > 0) begin
      if (wcnt >= mem_delay) begin
        bus.i_mem_r     = 1'b1;
        bus.i_mem_rdata = mem[bus.o_mem_addr];
        if (bus.o_mem_we) begin
          mem[bus.o_mem_addr] = bus.o_mem_wdata;
          wr_count++;
          wr_addr = bus.o_mem_addr;
          wr_data = bus.o_mem_wdata;
        end
        grants_left--;
        wcnt = 0;
      end else begin
        bus.i_mem_r     = 1'b0;
        bus.i_mem_rdata = 16'hDEAD;
        wcnt++;
      end
    end else begin
      bus.i_mem_r     = 1'b0;
      bus.i_mem_rdata = 16'hDEAD;
      wcnt = 0;
    end
  end

  always @(negedge i_clk) if (bus.o_done) done_cnt++;

  task automatic issue(input lc3_op_t op, input logic [15:0] addr, input logic [15:0] wd);
    @(negedge i_clk);
    bus.i_req   = 1'b1;
    bus.i_op    = op;
    bus.i_addr  = addr;
    bus.i_wdata = wd;
    @(negedge i_clk);
    bus.i_req   = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n     = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_op    = OP_ST;
    bus.i_addr  = 16'h1111;
    bus.i_wdata = 16'h2222;
    repeat (3) @(negedge i_clk);
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", bus.o_done); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.o_err); end
    checks++; if (bus.o_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%04h exp=0000", bus.o_rdata); end
    checks++; if (bus.o_mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0h exp=0", bus.o_mem_en); end
    checks++; if (bus.o_mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h exp=0", bus.o_mem_we); end
    checks++; if (bus.o_mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%04h exp=0000", bus.o_mem_addr); end
    checks++; if (bus.o_mem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_mem_wdata got=%04h exp=0000", bus.o_mem_wdata); end
    bus.i_req = 1'b0;
    i_rst_n   = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%0h exp=0", bus.o_busy); end
  endtask

  task automatic test_ld();
    mem[16'h3000] = 16'hBEEF;
    mem_delay = 0;
    issue(OP_LD, 16'h3000, 16'h0000);
    // ACC1
    checks++; if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin failures++; $display("FAIL ld_acc1_busy got=%0h/%0h exp=1/0", bus.o_busy, bus.o_done); end
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 16'h3000) begin
      failures++; $display("FAIL ld_acc1_bus got en=%0h we=%0h addr=%04h exp 1 0 3000", bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr); end
    @(negedge i_clk);
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL ld_latency got=%0h exp=1", bus.o_done); end
    checks++; if (bus.o_rdata !== 16'hBEEF || bus.o_err !== 1'b0) begin failures++; $display("FAIL ld_rdata got=%04h err=%0h exp=beef 0", bus.o_rdata, bus.o_err); end
    checks++; if (bus.o_mem_en !== 1'b0) begin failures++; $display("FAIL ld_done_en got=%0h exp=0", bus.o_mem_en); end
    @(negedge i_clk);
    checks++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_rdata !== 16'hBEEF) begin
      failures++; $display("FAIL ld_idle got done=%0h busy=%0h rdata=%04h exp 0 0 beef", bus.o_done, bus.o_busy, bus.o_rdata); end
  endtask

  task automatic test_st();
    int wc0;
    wc0 = wr_count;
    mem_delay = 1;
    issue(OP_ST, 16'h2000, 16'hCAFE);
    checks++; if (bus.o_mem_we !== 1'b1 || bus.o_mem_wdata !== 16'hCAFE || bus.o_mem_addr !== 16'h2000) begin
      failures++; $display("FAIL st_acc1 got we=%0h wd=%04h addr=%04h exp 1 cafe 2000", bus.o_mem_we, bus.o_mem_wdata, bus.o_mem_addr); end
    @(negedge i_clk);
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_done !== 1'b0) begin failures++; $display("FAIL st_hold got en=%0h done=%0h exp 1 0", bus.o_mem_en, bus.o_done); end
    @(negedge i_clk);
    checks++; if (bus.o_done !== 1'b1 || bus.o_rdata !== 16'hBEEF) begin failures++; $display("FAIL st_done got done=%0h rdata=%04h exp 1 beef", bus.o_done, bus.o_rdata); end
    checks++; if (wr_count - wc0 !== 1 || mem[16'h2000] !== 16'hCAFE) begin failures++; $display("FAIL st_write got n=%0d mem=%04h exp 1 cafe", wr_count - wc0, mem[16'h2000]); end
    @(negedge i_clk);
  endtask

  task automatic test_sti();
    int wc0;
    int n;
    bit seen;
    wc0 = wr_count;
    mem[16'h3001] = 16'h4000;
    mem[16'h4000] = 16'h0000;
    mem_delay = 3;
    issue(OP_STI, 16'h3001, 16'h1234);
    checks++; if (bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 16'h3001) begin failures++; $display("FAIL sti_ptr_read got we=%0h addr=%04h exp 0 3001", bus.o_mem_we, bus.o_mem_addr); end
    seen = 0;
    n = 0;
    while (!seen && n < 40) begin
      if (bus.o_done) seen = 1; else begin @(negedge i_clk); n++; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL sti_timeout got no done exp done within 40"); end
    checks++; if (wr_count - wc0 !== 1 || wr_addr !== 16'h4000 || wr_data !== 16'h1234) begin
      failures++; $display("FAIL sti_write got n=%0d addr=%04h data=%04h exp 1 4000 1234", wr_count - wc0, wr_addr, wr_data); end
    checks++; if (bus.o_rdata !== 16'hBEEF || bus.o_err !== 1'b0) begin failures++; $display("FAIL sti_rdata got=%04h err=%0h exp beef 0", bus.o_rdata, bus.o_err); end
    checks++; if (mem[16'h3001] !== 16'h4000) begin failures++; $display("FAIL sti_ptr_intact got=%04h exp 4000", mem[16'h3001]); end
    @(negedge i_clk);
  endtask

  task automatic test_ldi_wrap();
    mem[16'hFFFF] = 16'h0000;
    mem[16'h0000] = 16'h00AA;
    mem_delay = 0;
    issue(OP_LDI, 16'hFFFF, 16'h0000);
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 16'hFFFF) begin
      failures++; $display("FAIL ldi_acc1 got en=%0h we=%0h addr=%04h exp 1 0 ffff", bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr); end
    @(negedge i_clk);
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 16'h0000 || bus.o_done !== 1'b0) begin
      failures++; $display("FAIL ldi_acc2 got en=%0h we=%0h addr=%04h done=%0h exp 1 0 0000 0", bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_done); end
    @(negedge i_clk);
    checks++; if (bus.o_done !== 1'b1 || bus.o_rdata !== 16'h00AA) begin failures++; $display("FAIL ldi_result got done=%0h rdata=%04h exp 1 00aa", bus.o_done, bus.o_rdata); end
    @(negedge i_clk);
  endtask

  task automatic test_ignore_req();
    int d0;
    int wc0;
    d0  = done_cnt;
    wc0 = wr_count;
    mem[16'h1234] = 16'h5A5A;
    mem_delay = 0;
    issue(OP_LD, 16'h1234, 16'h0000);
    // in ACC1: pulse a competing store
    bus.i_req = 1'b1; bus.i_op = OP_ST; bus.i_addr = 16'h7777; bus.i_wdata = 16'h9999;
    @(negedge i_clk);
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL ign_done got=%0h exp=1", bus.o_done); end
    // still high during DONE, dropped before the following IDLE edge
    @(negedge i_clk);
    bus.i_req = 1'b0;
    repeat (4) @(negedge i_clk);
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (wr_count !== wc0 || bus.o_busy !== 1'b0 || bus.o_rdata !== 16'h5A5A) begin
      failures++; $display("FAIL ign_state got wr=%0d busy=%0h rdata=%04h exp %0d 0 5a5a", wr_count, bus.o_busy, bus.o_rdata, wc0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    mem[16'h0100] = 16'h1111;
    mem[16'h0101] = 16'h2222;
    mem_delay = 0;
    @(negedge i_clk);
    bus.i_req = 1'b1; bus.i_op = OP_LD; bus.i_addr = 16'h0100;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++; if (bus.o_done !== 1'b1 || bus.o_rdata !== 16'h1111) begin failures++; $display("FAIL b2b_first got done=%0h rdata=%04h exp 1 1111", bus.o_done, bus.o_rdata); end
    @(negedge i_clk);
    bus.i_addr = 16'h0101;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%0h exp 0", bus.o_busy); end
    @(negedge i_clk);
    @(negedge i_clk);
    checks++; if (bus.o_done !== 1'b1 || bus.o_rdata !== 16'h2222) begin failures++; $display("FAIL b2b_second got done=%0h rdata=%04h exp 1 2222", bus.o_done, bus.o_rdata); end
    bus.i_req = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    mem[16'h5000] = 16'h6000;
    mem_delay = 0;
    grants_left = 1;
    issue(OP_LDI, 16'h5000, 16'h0000);
    repeat (4) @(negedge i_clk);
    checks++; if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 16'h6000 || bus.o_busy !== 1'b1) begin
      failures++; $display("FAIL mid_waiting got en=%0h addr=%04h busy=%0h exp 1 6000 1", bus.o_mem_en, bus.o_mem_addr, bus.o_busy); end
    d0 = done_cnt;
    #1 i_rst_n = 1'b0;
    #1;
    checks++; if (bus.o_mem_en !== 1'b0 || bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_async got en=%0h busy=%0h exp 0 0", bus.o_mem_en, bus.o_busy); end
    checks++; if (bus.o_mem_addr !== 16'h0000 || bus.o_rdata !== 16'h0000) begin
      failures++; $display("FAIL mid_regs got addr=%04h rdata=%04h exp 0000 0000", bus.o_mem_addr, bus.o_rdata); end
    grants_left = 1000000;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    checks++; if (done_cnt !== d0 || bus.o_busy !== 1'b0) begin failures++; $display("FAIL mid_no_done got n=%0d busy=%0h exp 0 0", done_cnt - d0, bus.o_busy); end
  endtask

`ifdef LC3_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int en_cycles;
    bit seen;
    grants_left = 0;
    issue(OP_LD, 16'h3000, 16'h0000);
    seen = 0; n = 0; en_cycles = 0;
    while (!seen && n < 400) begin
      if (bus.o_done) seen = 1;
      else begin
        if (bus.o_mem_en) en_cycles++;
        @(negedge i_clk); n++;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL to_no_done got none exp done within 400"); end
    checks++; if (bus.o_err !== 1'b1 || bus.o_rdata !== 16'h0000) begin failures++; $display("FAIL to_result got err=%0h rdata=%04h exp 1 0000", bus.o_err, bus.o_rdata); end
    checks++; if (en_cycles !== 255) begin failures++; $display("FAIL to_cycles got=%0d exp=255", en_cycles); end
    grants_left = 1000000;
    @(negedge i_clk);
  endtask
`endif

  initial begin
    bus.i_req = 1'b0;
    bus.i_op = OP_LD;
    bus.i_addr = '0;
    bus.i_wdata = '0;
    bus.i_mem_r = 1'b0;
    bus.i_mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
    test_reset();
    test_ld();
    test_st();
    test_sti();
    test_ldi_wrap();
    test_ignore_req();
    test_back_to_back();
    test_reset_mid();
`ifdef LC3_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
